// File: rtl/cva6_hpdcache_mem_read_mux_nport_pkg.sv
// Shared types and helpers for the N-port HPDcache memory read mux.
// A requester port index is carried in the ID bits directly above the requester ID.
// That is how responses find their way back without a routing table.
package cva6_hpdcache_mem_read_mux_nport_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_ID_W   = 8;

  typedef enum logic [1:0] {
    MEM_CMD_READ  = 2'd0,
    MEM_CMD_WRITE = 2'd1,
    MEM_CMD_ATOM  = 2'd2
  } mem_cmd_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [MEM_ID_W-1:0]   id;
    mem_cmd_e              command;
    logic [3:0]            atomic;
    logic                  cacheable;
  } mem_req_t;

  typedef struct packed {
    logic [1:0]            error;
    logic [MEM_ID_W-1:0]   id;
    logic [MEM_DATA_W-1:0] data;
    logic                  last;
  } mem_resp_r_t;

  // Width of a counter that has to hold the values 0..max_out inclusive.
  function automatic int unsigned outstanding_cnt_width(int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  // Place the port index above the low in_w bits of the requester ID.
  function automatic logic [MEM_ID_W-1:0] tag_id(int unsigned port,
                                                 logic [MEM_ID_W-1:0] in_id,
                                                 int unsigned in_w);
    logic [MEM_ID_W-1:0] mask;
    mask = (MEM_ID_W'(1) << in_w) - MEM_ID_W'(1);
    return (MEM_ID_W'(port) << in_w) | (in_id & mask);
  endfunction

  // Recover the requester ID by dropping everything above the low in_w bits.
  function automatic logic [MEM_ID_W-1:0] untag_id(logic [MEM_ID_W-1:0] id,
                                                   int unsigned in_w);
    logic [MEM_ID_W-1:0] mask;
    mask = (MEM_ID_W'(1) << in_w) - MEM_ID_W'(1);
    return id & mask;
  endfunction

endpackage

// File: rtl/cva6_hpdcache_rr_arbiter.sv
// N-way round-robin arbiter with a request mask and a grant lock.
// The search starts at the pointer.
// The pointer moves past the winner only when the grant is accepted.
// An unaccepted grant stays locked while its requester remains eligible.
module cva6_hpdcache_rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    mask_i,
  input  logic            accept_i,
  output logic [N-1:0]    gnt_o,
  output logic            gnt_valid_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [N-1:0]    eligible;
  logic            found;
  logic [IdxW-1:0] sel;
  int unsigned     cand;

  // Pick the first eligible requester at or after the pointer; a live lock wins.
  always_comb begin
    eligible = req_i & mask_i;
    found    = 1'b0;
    sel      = '0;
    cand     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_q) + i) % N;
      if (!found && eligible[IdxW'(cand)]) begin
        found = 1'b1;
        sel   = IdxW'(cand);
      end
    end
    if (lock_q && eligible[lock_idx_q]) begin
      found = 1'b1;
      sel   = lock_idx_q;
    end
    gnt_o = '0;
    if (found) gnt_o[sel] = 1'b1;
    gnt_valid_o = found;
    gnt_idx_o   = sel;
  end

  // Advance the pointer on acceptance; otherwise hold any pending grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (accept_i) begin
      ptr_q  <= (sel == IdxW'(N - 1)) ? '0 : sel + IdxW'(1);
      lock_q <= 1'b0;
    end else begin
      lock_q     <= found;
      lock_idx_q <= sel;
    end
  end

endmodule

// File: rtl/cva6_hpdcache_mem_read_mux_nport.sv
// N-port read-request arbiter and response router in front of one memory read channel.
// Handshake rule on every channel: a transfer happens in a cycle where valid and ready
// are both 1; once valid is raised toward memory, the payload holds until ready is seen.
module cva6_hpdcache_mem_read_mux_nport
  import cva6_hpdcache_mem_read_mux_nport_pkg::*;
#(
  parameter int unsigned NumPorts       = 3,
  parameter int unsigned InIdWidth      = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned PortSelWidth  = $clog2(NumPorts),
  localparam int unsigned OutIdWidth    = InIdWidth + PortSelWidth,
  localparam int unsigned CntWidth      = outstanding_cnt_width(MaxOutstanding)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic        [NumPorts-1:0]         req_valid_i,
  output logic        [NumPorts-1:0]         req_ready_o,
  input  mem_req_t    [NumPorts-1:0]         req_i,
  output logic        [NumPorts-1:0]         resp_valid_o,
  input  logic        [NumPorts-1:0]         resp_ready_i,
  output mem_resp_r_t [NumPorts-1:0]         resp_o,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output mem_req_t                           mem_req_o,
  input  logic                               mem_resp_valid_i,
  output logic                               mem_resp_ready_o,
  input  mem_resp_r_t                        mem_resp_i,
  output logic        [NumPorts-1:0][CntWidth-1:0] outstanding_o,
  output logic                               err_o
);

  logic [NumPorts-1:0]               below_limit;
  logic [NumPorts-1:0]               gnt;
  logic                              gnt_valid;
  logic [PortSelWidth-1:0]           gnt_idx;
  logic                              can_accept;
  logic                              accept;
  mem_req_t                          gnt_req;
  logic                              out_valid_q;
  mem_req_t                          out_req_q;
  logic [NumPorts-1:0][CntWidth-1:0] cnt_q;
  logic [NumPorts-1:0]               inc;
  logic [NumPorts-1:0]               dec;
  logic [PortSelWidth-1:0]           resp_port;
  logic                              resp_port_ok;
  logic                              resp_hs;
  logic                              underflow;
  logic                              err_q;

  // A port at its in-flight limit is masked out of arbitration.
  always_comb begin
    for (int unsigned p = 0; p < NumPorts; p++) begin
      below_limit[p] = cnt_q[p] < CntWidth'(MaxOutstanding);
    end
  end

  cva6_hpdcache_rr_arbiter #(
    .N (NumPorts)
  ) i_rr_arbiter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_valid_i),
    .mask_i      (below_limit),
    .accept_i    (accept),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign can_accept  = !out_valid_q || mem_req_ready_i;
  assign accept      = can_accept && gnt_valid;
  assign req_ready_o = can_accept ? gnt : '0;

  // Granted request with the port index folded into its ID.
  always_comb begin
    gnt_req    = req_i[gnt_idx];
    gnt_req.id = tag_id(32'(gnt_idx), req_i[gnt_idx].id, InIdWidth);
  end

  // One-entry output register: load on acceptance, empty when drained with nothing new.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_req_q   <= gnt_req;
    end else if (mem_req_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign mem_req_valid_o = out_valid_q;
  assign mem_req_o       = out_req_q;

  assign resp_port    = mem_resp_i.id[OutIdWidth-1:InIdWidth];
  assign resp_port_ok = 32'(resp_port) < NumPorts;

  // Route the response to the port named in its ID; an unknown port is sunk.
  always_comb begin
    resp_valid_o     = '0;
    mem_resp_ready_o = 1'b1;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      resp_o[p]    = mem_resp_i;
      resp_o[p].id = untag_id(mem_resp_i.id, InIdWidth);
      if (resp_port_ok && resp_port == PortSelWidth'(p)) begin
        resp_valid_o[p]  = mem_resp_valid_i;
        mem_resp_ready_o = resp_ready_i[p];
      end
    end
  end

  assign resp_hs = mem_resp_valid_i && mem_resp_ready_o;

  // Per-port counter events and detection of a last beat nobody was waiting for.
  always_comb begin
    underflow = 1'b0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      inc[p] = accept && gnt[p];
      dec[p] = resp_hs && resp_valid_o[p] && mem_resp_i.last;
      if (dec[p] && cnt_q[p] == '0) underflow = 1'b1;
    end
  end

  // In-flight counters; equal increment and decrement cancel, and zero never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (inc[p] && !dec[p]) begin
          cnt_q[p] <= cnt_q[p] + CntWidth'(1);
        end else if (dec[p] && !inc[p] && cnt_q[p] != '0) begin
          cnt_q[p] <= cnt_q[p] - CntWidth'(1);
        end
      end
    end
  end

  // Sticky error: set by a response to a nonexistent port or by counter underflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((resp_hs && !resp_port_ok) || underflow) begin
      err_q <= 1'b1;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cva6_hpdcache_mem_read_mux_nport.sv
// Directed bench for the N-port memory read mux.
module tb_cva6_hpdcache_mem_read_mux_nport;
  import cva6_hpdcache_mem_read_mux_nport_pkg::*;

  localparam int unsigned NP = 3;

  logic                    clk_i;
  logic                    rst_ni;
  logic        [NP-1:0]    req_valid_i;
  logic        [NP-1:0]    req_ready_o;
  mem_req_t    [NP-1:0]    req_i;
  logic        [NP-1:0]    resp_valid_o;
  logic        [NP-1:0]    resp_ready_i;
  mem_resp_r_t [NP-1:0]    resp_o;
  logic                    mem_req_valid_o;
  logic                    mem_req_ready_i;
  mem_req_t                mem_req_o;
  logic                    mem_resp_valid_i;
  logic                    mem_resp_ready_o;
  mem_resp_r_t             mem_resp_i;
  logic [NP-1:0][2:0]      outstanding_o;
  logic                    err_o;

  int errors = 0;
  int checks = 0;

  cva6_hpdcache_mem_read_mux_nport #(
    .NumPorts       (NP),
    .InIdWidth      (4),
    .MaxOutstanding (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_i            (req_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_o           (resp_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_o        (mem_req_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_resp_i       (mem_resp_i),
    .outstanding_o    (outstanding_o),
    .err_o            (err_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    req_valid_i      = '0;
    req_i            = '0;
    resp_ready_i     = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_i       = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (mem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req_valid: got %0b expected 0", mem_req_valid_o);
    end
    checks++;
    if (resp_valid_o !== 3'b000) begin
      errors++; $display("FAIL reset_resp_valid: got %b expected 000", resp_valid_o);
    end
    checks++;
    if (outstanding_o !== 9'd0) begin
      errors++; $display("FAIL reset_outstanding: got %h expected 0", outstanding_o);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %0b expected 0", err_o);
    end
  endtask

  task automatic test_round_robin();
    int exp_port [4] = '{0, 1, 2, 0};
    logic [7:0]  exp_id;
    logic [31:0] exp_addr;
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      req_i[p].id   = 8'(p + 1);
      req_i[p].addr = 32'h1000 * 32'(p + 1);
    end
    req_valid_i     = 3'b111;
    mem_req_ready_i = 1'b1;
    #1;
    checks++;
    if (mem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL rr_no_early_output: got %0b expected 0", mem_req_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_ready_o !== 3'(1 << exp_port[i])) begin
        errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, req_ready_o, 3'(1 << exp_port[i]));
      end
      tick();
      if (i == 3) req_valid_i = '0;
      exp_id   = 8'((exp_port[i] << 4) | (exp_port[i] + 1));
      exp_addr = 32'h1000 * 32'(exp_port[i] + 1);
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_o.id !== exp_id || mem_req_o.addr !== exp_addr) begin
        errors++;
        $display("FAIL rr_out_%0d: got v=%0b id=%h addr=%h expected v=1 id=%h addr=%h",
                 i, mem_req_valid_o, mem_req_o.id, mem_req_o.addr, exp_id, exp_addr);
      end
    end
    checks++;
    if (outstanding_o !== {3'd1, 3'd1, 3'd2}) begin
      errors++; $display("FAIL rr_outstanding: got %h expected %h", outstanding_o, {3'd1, 3'd1, 3'd2});
    end
    tick();
    checks++;
    if (mem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL rr_drained: got %0b expected 0", mem_req_valid_o);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_i[1].id   = 8'h07;
    req_i[1].addr = 32'h0000_0100;
    req_valid_i   = 3'b010;
    #1;
    checks++;
    if (req_ready_o !== 3'b010) begin
      errors++; $display("FAIL bp_first_ready: got %b expected 010", req_ready_o);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_o.id !== 8'h17 || mem_req_o.addr !== 32'h100) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%0b id=%h addr=%h expected v=1 id=17 addr=100",
                 i, mem_req_valid_o, mem_req_o.id, mem_req_o.addr);
      end
      checks++;
      if (req_ready_o !== 3'b000) begin
        errors++; $display("FAIL bp_ready_low_%0d: got %b expected 000", i, req_ready_o);
      end
      tick();
    end
    mem_req_ready_i = 1'b1;
    req_valid_i     = 3'b000;
    tick();
    checks++;
    if (mem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_single_issue: got %0b expected 0", mem_req_valid_o);
    end
    checks++;
    if (outstanding_o[1] !== 3'd1) begin
      errors++; $display("FAIL bp_outstanding: got %0d expected 1", outstanding_o[1]);
    end
  endtask

  task automatic test_outstanding_limit();
    apply_reset();
    req_valid_i     = 3'b001;
    mem_req_ready_i = 1'b1;
    repeat (4) tick();
    checks++;
    if (outstanding_o[0] !== 3'd4) begin
      errors++; $display("FAIL lim_count4: got %0d expected 4", outstanding_o[0]);
    end
    checks++;
    if (req_ready_o !== 3'b000) begin
      errors++; $display("FAIL lim_port0_blocked: got %b expected 000", req_ready_o);
    end
    req_valid_i = 3'b011;
    #1;
    checks++;
    if (req_ready_o !== 3'b010) begin
      errors++; $display("FAIL lim_other_granted: got %b expected 010", req_ready_o);
    end
    tick();
    req_valid_i         = 3'b001;
    mem_resp_valid_i    = 1'b1;
    mem_resp_i.id       = 8'h03;
    mem_resp_i.last     = 1'b1;
    resp_ready_i        = 3'b001;
    #1;
    checks++;
    if (resp_valid_o !== 3'b001 || mem_resp_ready_o !== 1'b1) begin
      errors++; $display("FAIL lim_resp_route: got valid=%b ready=%0b expected 001/1", resp_valid_o, mem_resp_ready_o);
    end
    tick();
    mem_resp_valid_i = 1'b0;
    resp_ready_i     = '0;
    #1;
    checks++;
    if (outstanding_o[0] !== 3'd3) begin
      errors++; $display("FAIL lim_count3: got %0d expected 3", outstanding_o[0]);
    end
    checks++;
    if (req_ready_o !== 3'b001) begin
      errors++; $display("FAIL lim_regrant: got %b expected 001", req_ready_o);
    end
  endtask

  task automatic test_burst_response();
    int beat;
    int cyc;
    logic hs;
    apply_reset();
    req_i[2].id     = 8'h05;
    req_valid_i     = 3'b100;
    mem_req_ready_i = 1'b1;
    tick();
    req_valid_i = '0;
    checks++;
    if (outstanding_o[2] !== 3'd1) begin
      errors++; $display("FAIL burst_issue: got %0d expected 1", outstanding_o[2]);
    end
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 20) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_i.id    = 8'h25;
      mem_resp_i.data  = 64'hA0 + 64'(beat);
      mem_resp_i.last  = (beat == 3);
      resp_ready_i     = (cyc % 2 == 0) ? 3'b100 : 3'b000;
      hs               = resp_ready_i[2];
      #1;
      checks++;
      if (resp_valid_o !== 3'b100 || resp_o[2].id !== 8'h05 || resp_o[2].data !== 64'hA0 + 64'(beat)
          || mem_resp_ready_o !== hs) begin
        errors++;
        $display("FAIL burst_beat_%0d: got valid=%b id=%h data=%h ready=%0b expected 100/05/%h/%0b",
                 beat, resp_valid_o, resp_o[2].id, resp_o[2].data, mem_resp_ready_o,
                 64'hA0 + 64'(beat), hs);
      end
      tick();
      if (hs) begin
        beat++;
        checks++;
        if (outstanding_o[2] !== ((beat == 4) ? 3'd0 : 3'd1)) begin
          errors++;
          $display("FAIL burst_count_%0d: got %0d expected %0d", beat, outstanding_o[2], (beat == 4) ? 0 : 1);
        end
      end
      cyc++;
    end
    checks++;
    if (beat != 4) begin
      errors++; $display("FAIL burst_timeout: got %0d beats expected 4", beat);
    end
    mem_resp_valid_i = 1'b0;
    resp_ready_i     = '0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req_valid_i     = 3'b010;
    mem_req_ready_i = 1'b1;
    tick();
    mem_resp_valid_i = 1'b1;
    mem_resp_i.id    = 8'h10;
    mem_resp_i.last  = 1'b1;
    resp_ready_i     = 3'b010;
    #1;
    checks++;
    if (req_ready_o[1] !== 1'b1 || resp_valid_o !== 3'b010) begin
      errors++; $display("FAIL sim_both_active: got ready=%b resp_valid=%b expected x1x/010", req_ready_o, resp_valid_o);
    end
    tick();
    req_valid_i      = '0;
    mem_resp_valid_i = 1'b0;
    resp_ready_i     = '0;
    checks++;
    if (outstanding_o[1] !== 3'd1) begin
      errors++; $display("FAIL sim_unchanged: got %0d expected 1", outstanding_o[1]);
    end
  endtask

  task automatic test_errors_and_reset();
    apply_reset();
    mem_resp_valid_i = 1'b1;
    mem_resp_i.id    = 8'h30;
    mem_resp_i.last  = 1'b1;
    #1;
    checks++;
    if (mem_resp_ready_o !== 1'b1 || resp_valid_o !== 3'b000) begin
      errors++; $display("FAIL err_drop: got ready=%0b valid=%b expected 1/000", mem_resp_ready_o, resp_valid_o);
    end
    tick();
    mem_resp_valid_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %0b expected 1", err_o);
    end
    req_valid_i = 3'b001;
    tick();
    req_valid_i      = '0;
    mem_resp_valid_i = 1'b1;
    mem_resp_i.id    = 8'h25;
    mem_resp_i.last  = 1'b0;
    resp_ready_i     = 3'b100;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (outstanding_o !== 9'd0 || mem_req_valid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got cnt=%h v=%0b err=%0b expected 0/0/0", outstanding_o, mem_req_valid_o, err_o);
    end
    clear_inputs();
    tick();
    rst_ni           = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_resp_i.id    = 8'h25;
    mem_resp_i.last  = 1'b1;
    resp_ready_i     = 3'b100;
    #1;
    checks++;
    if (resp_valid_o !== 3'b100) begin
      errors++; $display("FAIL underflow_forward: got %b expected 100", resp_valid_o);
    end
    tick();
    mem_resp_valid_i = 1'b0;
    resp_ready_i     = '0;
    checks++;
    if (err_o !== 1'b1 || outstanding_o[2] !== 3'd0) begin
      errors++; $display("FAIL underflow_err: got err=%0b cnt=%0d expected 1/0", err_o, outstanding_o[2]);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_outstanding_limit();
    test_burst_response();
    test_simultaneous();
    test_errors_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cva6_hpdcache_mem_read_mux_nport.md
Name: cva6_hpdcache_mem_read_mux_nport

Overview:
- N-port read-request arbiter and response router between several HPDcache-style read requesters and one shared memory read channel. Typical requesters: I$ refill, D$ miss, prefetcher, PTW.
- Sits in front of the mem-to-AXI read adapter.
- Adds features the two-port version lacks:
  - round-robin arbitration with grant lock;
  - requester-index ID tagging, so no external routing table is needed;
  - per-port outstanding-transaction limiting;
  - a registered output stage;
  - sticky error reporting.

Parameters:
- NumPorts, 3, number of requesters (>=2).
- InIdWidth, 4, request/response ID width on each requester port.
- PortSelWidth, $clog2(NumPorts), derived; number of upper ID bits carrying the port index.
- OutIdWidth, InIdWidth+PortSelWidth, derived; ID width toward memory.
- MaxOutstanding, 4, maximum in-flight read transactions per port (>=1).
- mem_req_t, logic, request payload type (addr, len, size, id, command, atomic, cacheable).
- mem_resp_r_t, logic, read response payload type (error, id, data, last).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumPorts  per-port request valid
- req_ready_o  out  NumPorts  per-port request ready
- req_i  in  NumPorts x mem_req_t  per-port request; only the low InIdWidth id bits are used
- resp_valid_o  out  NumPorts  per-port response valid
- resp_ready_i  in  NumPorts  per-port response ready
- resp_o  out  NumPorts x mem_resp_r_t  per-port response, id stripped to InIdWidth
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream request ready
- mem_req_o  out  mem_req_t  downstream request, id = {port index, in id}
- mem_resp_valid_i  in  1  downstream response valid
- mem_resp_ready_o  out  1  downstream response ready
- mem_resp_i  in  mem_resp_r_t  downstream response
- outstanding_o  out  NumPorts x $clog2(MaxOutstanding+1)  per-port in-flight count
- err_o  out  1  sticky error flag

Behaviour:
- Reset values: mem_req_valid_o=0, resp_valid_o=0, outstanding_o=0, err_o=0, RR pointer=0, output register empty.
- Eligibility: port p is eligible when req_valid_i[p]=1 and outstanding[p] < MaxOutstanding.
- Arbitration: round-robin among eligible ports, starting at the RR pointer.
  - On acceptance, the pointer moves to the granted port + 1, wrapping modulo NumPorts.
  - req_ready_o[p] is 1 only for the granted port, and only when the output register is empty or being drained this cycle.
- Output stage: one-entry register.
  - Captures the granted request with id = {p[PortSelWidth-1:0], req_i[p].id[InIdWidth-1:0]}.
  - Latency: request accepted in cycle t appears on mem_req_o in cycle t+1.
  - Full throughput of one request per cycle when mem_req_ready_i=1.
  - While mem_req_valid_o=1 and mem_req_ready_i=0, mem_req_o and mem_req_valid_o hold stable (AXI rule). No new grant is issued unless the register drains this cycle.
- Outstanding counters:
  - Increment: when a port's request is accepted into the output stage. Counting at acceptance prevents over-issue.
  - Decrement: on a response handshake to that port with last=1.
  - Simultaneous increment and decrement in the same cycle: count unchanged.
  - The counter never exceeds MaxOutstanding, because the port becomes ineligible at the limit.
- Response routing:
  - Target port q = mem_resp_i.id[OutIdWidth-1:InIdWidth].
  - resp_valid_o[q] = mem_resp_valid_i; mem_resp_ready_o = resp_ready_i[q]; resp_o[q].id = low InIdWidth bits.
  - Purely combinational path, zero latency.
  - Bursts are routed beat by beat; there is no interleaving restriction beyond the ID.
- Errors (err_o is set and stays set until reset):
  - q >= NumPorts: response is dropped with mem_resp_ready_o=1 and no port sees valid.
  - A last-beat response arrives for a port whose outstanding count is 0: response is forwarded and the counter stays at 0 (no underflow).
- Reset mid-operation: all counters, the RR pointer and the output register clear immediately; in-flight responses after reset count as underflow errors.
- Unused resp_o[p] lanes carry the mem_resp_i payload; only resp_valid_o gates them.

Decomposition:
- The shared package (hpdcache_pkg extension) holds:
  - the port-index tag helper functions (tag/untag ID);
  - the outstanding-count width localparam function.
- One natural sub-module: cva6_hpdcache_rr_arbiter. It provides an N-way round-robin arbiter with request mask, grant lock and pointer update on acceptance, and is reusable by the write-path mux.
- The output register reuses hpdcache_fifo_reg with depth 1.

Test Plan:
1. Ports 0,1,2 all valid from reset, mem_req_ready_i=1 constant -> grants in order 0,1,2,0. Output ids {0,id0},{1,id1},{2,id2}. Each appears one cycle after acceptance.
2. Port 1 holds valid, mem_req_ready_i=0 for 5 cycles -> mem_req_o stable for all 5 cycles. req_ready_o=0 for all ports after the register fills. A single request is issued when ready rises.
3. MaxOutstanding=4, port 0 issues 4 requests with no responses -> outstanding_o[0]=4 and req_ready_o[0]=0. Other ports still granted. One last-beat response to port 0 -> count 3 and port 0 grantable next cycle.
4. 4-beat burst with id {2,4'h5}, resp_ready_i[2] toggling -> port 2 receives 4 beats with id 5. outstanding_o[2] decrements only on the beat with last=1.
5. Same cycle: port 1 accepted and a last-beat response for port 1 -> outstanding_o[1] unchanged.
6. Response with port field 3 (NumPorts=3) -> mem_resp_ready_o=1, no resp_valid_o asserted, err_o=1 persisting. Assert rst_ni=0 mid-burst -> all counters 0, mem_req_valid_o=0, err_o=0.
